// File: rtl/seven_seg_capture.sv
// Purpose : samples a multiplexed active-low seven-segment bus and rebuilds the hex nibble on each digit.
// Latency : a pin value first sampled at edge E0 and held appears on value/digit_valid/err at edge E0+STABLE_CYCLES+2.
// Backpressure: none; this is a passive sniffer, so the display is never stalled and every event is reported as it happens.
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   seg_n        active-low segments a..g (bit0 = a), asynchronous to clk
//   dig_n        active-low digit enables, bit i = digit i, asynchronous to clk
//   value        decoded nibbles, digit i at [4i+3:4i]
//   digit_valid  bit i set while nibble i holds a successfully decoded pattern
//   err          one-cycle pulse on an illegal pattern or an illegal digit-enable combination
//   frame_done   one-cycle pulse once every digit has been accepted since the previous pulse
//   stale        one-cycle pulse when no digit has been accepted for TIMEOUT_CYCLES
module seven_seg_capture #(
  parameter int NUM_DIGITS     = 4,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   dig_n,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    err,
  output logic                    frame_done,
  output logic                    stale
);

  localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] STAB_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  // One snapshot of the bus: digit enables above segments.
  typedef struct packed {
    logic [NUM_DIGITS-1:0] dig;
    logic [6:0]            seg;
  } sample_t;

  sample_t s1, s2, prev;

  logic [CW-1:0]         stab_cnt;
  logic                  locked;
  logic [TW-1:0]         tmo_cnt;
  logic [NUM_DIGITS-1:0] seen;

  logic                    same;
  logic                    accept;
  logic [NUM_DIGITS-1:0]   dig_act;
  logic                    acc_single;
  logic                    acc_multi;
  logic [4:0]              dec;
  logic                    pat_hit;
  logic [3:0]              pat_nib;

  logic [4*NUM_DIGITS-1:0] value_nxt;
  logic [NUM_DIGITS-1:0]   valid_nxt;
  logic [NUM_DIGITS-1:0]   seen_nxt;
  logic [TW-1:0]           tmo_nxt;
  logic                    err_nxt;
  logic                    fd_nxt;
  logic                    stale_nxt;

  // Lit-segment pattern to {hit, nibble}; anything outside the hex font is a miss.
  function automatic logic [4:0] decode_seg(input logic [6:0] pat);
    case (pat)
      7'h3F:   decode_seg = {1'b1, 4'h0};
      7'h06:   decode_seg = {1'b1, 4'h1};
      7'h5B:   decode_seg = {1'b1, 4'h2};
      7'h4F:   decode_seg = {1'b1, 4'h3};
      7'h66:   decode_seg = {1'b1, 4'h4};
      7'h6D:   decode_seg = {1'b1, 4'h5};
      7'h7D:   decode_seg = {1'b1, 4'h6};
      7'h07:   decode_seg = {1'b1, 4'h7};
      7'h7F:   decode_seg = {1'b1, 4'h8};
      7'h6F:   decode_seg = {1'b1, 4'h9};
      7'h77:   decode_seg = {1'b1, 4'hA};
      7'h7C:   decode_seg = {1'b1, 4'hB};
      7'h39:   decode_seg = {1'b1, 4'hC};
      7'h5E:   decode_seg = {1'b1, 4'hD};
      7'h79:   decode_seg = {1'b1, 4'hE};
      7'h71:   decode_seg = {1'b1, 4'hF};
      default: decode_seg = 5'h00;
    endcase
  endfunction

  // Two-flop synchroniser followed by the previous-sample register. Reset
  // loads the idle (all-ones) bus so the filter starts out matching blanking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= '1;
      s2   <= '1;
      prev <= '1;
    end else begin
      s1   <= sample_t'({dig_n, seg_n});
      s2   <= s1;
      prev <= s2;
    end
  end

  assign same   = (s2 == prev);
  // The lock keeps a long-held value from being accepted again while the
  // counter sits saturated at its terminal count.
  assign accept = same && (stab_cnt == STAB_LAST) && !locked;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stab_cnt <= '0;
      locked   <= 1'b0;
    end else if (!same) begin
      stab_cnt <= '0;
      locked   <= 1'b0;
    end else begin
      if (stab_cnt != STAB_LAST) begin
        stab_cnt <= stab_cnt + CW'(1);
      end
      if (accept) begin
        locked <= 1'b1;
      end
    end
  end

  // Classification of the accepted sample. No enables active is blanking and
  // falls through both terms below, so it has no effect at all.
  assign dig_act    = ~s2.dig;
  assign acc_single = accept && $onehot(dig_act);
  assign acc_multi  = accept && (dig_act != '0) && !$onehot(dig_act);
  assign dec        = decode_seg(~s2.seg);
  assign pat_hit    = dec[4];
  assign pat_nib    = dec[3:0];

  always_comb begin
    value_nxt = value;
    valid_nxt = digit_valid;
    seen_nxt  = seen;
    tmo_nxt   = tmo_cnt + TW'(1);
    err_nxt   = acc_multi || (acc_single && !pat_hit);
    fd_nxt    = 1'b0;
    stale_nxt = 1'b0;

    // Frame completion: report and start a fresh mask. The digit that
    // completed the frame was recorded last cycle and is not carried over.
    if (&seen) begin
      fd_nxt   = 1'b1;
      seen_nxt = '0;
    end

    // A single-digit acceptance in the expiry cycle beats the timeout.
    if (acc_single) begin
      tmo_nxt = '0;
    end else if (tmo_cnt == TMO_LAST) begin
      tmo_nxt   = '0;
      stale_nxt = 1'b1;
      valid_nxt = '0;
      seen_nxt  = '0;
    end

    if (acc_single) begin
      seen_nxt = seen_nxt | dig_act;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (dig_act[i]) begin
          valid_nxt[i] = pat_hit;
          // A bad pattern keeps the last good nibble for the register bank.
          if (pat_hit) begin
            value_nxt[4*i +: 4] = pat_nib;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value       <= '0;
      digit_valid <= '0;
      seen        <= '0;
      tmo_cnt     <= '0;
      err         <= 1'b0;
      frame_done  <= 1'b0;
      stale       <= 1'b0;
    end else begin
      value       <= value_nxt;
      digit_valid <= valid_nxt;
      seen        <= seen_nxt;
      tmo_cnt     <= tmo_nxt;
      err         <= err_nxt;
      frame_done  <= fd_nxt;
      stale       <= stale_nxt;
    end
  end

endmodule

// File: tb/tb_seven_seg_capture.sv
// Bench for seven_seg_capture: the bus is driven as a list of held segments;
// each segment is turned into expected output events by a reference model,
// and a monitor pops and compares whenever the DUT shows an output event.
module tb_seven_seg_capture;

  localparam int ND = 4;
  localparam int SC = 4;
  localparam int TO = 50;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [6:0]    seg_n;
  logic [ND-1:0] dig_n;
  logic [4*ND-1:0] value;
  logic [ND-1:0] digit_valid;
  logic          err, frame_done, stale;

  seven_seg_capture #(
    .NUM_DIGITS    (ND),
    .STABLE_CYCLES (SC),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_n      (seg_n),
    .dig_n      (dig_n),
    .value      (value),
    .digit_valid(digit_valid),
    .err        (err),
    .frame_done (frame_done),
    .stale      (stale)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ND-1:0] dig;
    logic [6:0]    seg;
    int            len;
  } seg_t;

  typedef struct {
    int              edge_n;
    logic [4*ND-1:0] value;
    logic [ND-1:0]   valid;
    logic            err;
    logic            fd;
    logic            stale;
  } ev_t;

  seg_t plan[$];
  ev_t  exp_q[$];

  int tests = 0;
  int fails = 0;
  int ecnt  = 0;
  bit mon_en = 1'b0;

  // Hex font, lit segments, index = digit value.
  logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference state
  logic [4*ND-1:0] m_value;
  logic [ND-1:0]   m_valid;
  logic [ND-1:0]   m_seen;
  int              last_clear;
  logic [ND-1:0]   last_dig;
  logic [6:0]      last_seg;

  function automatic void model_reset();
    m_value    = '0;
    m_valid    = '0;
    m_seen     = '0;
    last_clear = 0;
    last_dig   = '1;
    last_seg   = 7'h7F;
  endfunction

  function automatic void push_ev(int n, logic e, logic f, logic s);
    ev_t ev;
    ev.edge_n = n;
    ev.value  = m_value;
    ev.valid  = m_valid;
    ev.err    = e;
    ev.fd     = f;
    ev.stale  = s;
    exp_q.push_back(ev);
  endfunction

  // Every timeout that expires strictly before edge lim.
  function automatic void model_stales_before(int lim);
    while (last_clear + TO < lim) begin
      last_clear = last_clear + TO;
      m_valid    = '0;
      m_seen     = '0;
      push_ev(last_clear, 1'b0, 1'b0, 1'b1);
    end
  endfunction

  function automatic void model_accept(int a, logic [ND-1:0] dig, logic [6:0] seg);
    logic [ND-1:0]   act;
    logic [4*ND-1:0] old_v;
    logic [ND-1:0]   old_val;
    logic            e, s, expire;
    int              code, idx;
    logic [6:0]      lit;
    model_stales_before(a);
    expire  = (last_clear + TO == a);
    act     = ~dig;
    lit     = ~seg;
    old_v   = m_value;
    old_val = m_valid;
    e       = 1'b0;
    s       = 1'b0;
    if ($countones(act) == 1) begin
      idx  = 0;
      code = -1;
      for (int k = 0; k < ND; k++) if (act[k]) idx = k;
      for (int k = 0; k < 16; k++) if (tbl[k] == lit) code = k;
      if (code >= 0) begin
        m_value[4*idx +: 4] = code[3:0];
        m_valid[idx] = 1'b1;
      end else begin
        m_valid[idx] = 1'b0;
        e = 1'b1;
      end
      m_seen[idx] = 1'b1;
      last_clear  = a;
    end else begin
      if ($countones(act) >= 2) e = 1'b1;
      if (expire) begin
        s          = 1'b1;
        m_valid    = '0;
        m_seen     = '0;
        last_clear = a;
      end
    end
    if (e || s || (m_value != old_v) || (m_valid != old_val)) push_ev(a, e, 1'b0, s);
    if (&m_seen) begin
      m_seen = '0;
      push_ev(a + 1, 1'b0, 1'b1, 1'b0);
    end
  endfunction

  function automatic void add(logic [ND-1:0] d, logic [6:0] lit, int len);
    seg_t sg;
    sg.dig = d;
    sg.seg = ~lit;
    sg.len = len;
    plan.push_back(sg);
    last_dig = d;
    last_seg = ~lit;
  endfunction

  // Called at #1 after a posedge; the first segment is sampled at the next edge.
  task automatic run_plan();
    int st;
    st = ecnt + 1;
    foreach (plan[k]) begin
      if (plan[k].len >= SC + 1) model_accept(st + SC + 2, plan[k].dig, plan[k].seg);
      st = st + plan[k].len;
    end
    model_stales_before(st);
    foreach (plan[k]) begin
      dig_n = plan[k].dig;
      seg_n = plan[k].seg;
      repeat (plan[k].len) @(posedge clk);
      #1;
    end
    plan.delete();
  endtask

  task automatic check_reset(string name);
    tests++;
    if (value !== '0 || digit_valid !== '0 || err !== 1'b0 || frame_done !== 1'b0 || stale !== 1'b0) begin
      fails++;
      $display("FAIL %s: value %h valid %b err %b fd %b stale %b, required all zero",
               name, value, digit_valid, err, frame_done, stale);
    end
  endtask

  task automatic add_random(int n);
    logic [ND-1:0] d, one;
    logic [6:0]    lit;
    int            r, len;
    one = 1;
    for (int k = 0; k < n; k++) begin
      do begin
        r = $urandom_range(0, 99);
        if (r < 60) begin
          d = ~(one << $urandom_range(0, ND - 1));
          if ($urandom_range(0, 3) != 0) lit = tbl[$urandom_range(0, 15)];
          else lit = 7'($urandom);
        end else if (r < 72) begin
          do d = ND'($urandom); while ($countones(~d) < 2);
          lit = 7'($urandom);
        end else begin
          d   = '1;
          lit = 7'($urandom);
        end
      end while (d == last_dig && ~lit == last_seg);
      if (d == '1 && $urandom_range(0, 9) == 0) len = $urandom_range(30, 80);
      else len = $urandom_range(1, 12);
      add(d, lit, len);
    end
  endtask

  // Monitor: an output event is any nibble/valid change or any pulse.
  initial begin
    logic [4*ND-1:0] pv;
    logic [ND-1:0]   pvl;
    ev_t             e;
    pv  = '0;
    pvl = '0;
    forever begin
      @(posedge clk);
      if (!rst_n) ecnt = 0;
      else ecnt++;
      #1;
      if (!(rst_n && mon_en)) begin
        pv  = value;
        pvl = digit_valid;
      end else begin
        while (exp_q.size() > 0 && exp_q[0].edge_n < ecnt) begin
          e = exp_q.pop_front();
          tests++;
          fails++;
          $display("FAIL missing_event: want edge %0d value %h valid %b err %b fd %b stale %b, got nothing by edge %0d",
                   e.edge_n, e.value, e.valid, e.err, e.fd, e.stale, ecnt);
        end
        if (value != pv || digit_valid != pvl || err || frame_done || stale) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event: got edge %0d value %h valid %b err %b fd %b stale %b, required no event",
                     ecnt, value, digit_valid, err, frame_done, stale);
          end else begin
            e = exp_q.pop_front();
            if (e.edge_n != ecnt || e.value !== value || e.valid !== digit_valid ||
                e.err !== err || e.fd !== frame_done || e.stale !== stale) begin
              fails++;
              $display("FAIL event: got edge %0d value %h valid %b err %b fd %b stale %b, want edge %0d value %h valid %b err %b fd %b stale %b",
                       ecnt, value, digit_valid, err, frame_done, stale,
                       e.edge_n, e.value, e.valid, e.err, e.fd, e.stale);
            end
          end
        end
        pv  = value;
        pvl = digit_valid;
      end
    end
  end

  initial begin
    logic [6:0]    scan [4];
    logic [ND-1:0] one;
    one   = 1;
    seg_n = 7'h7F;
    dig_n = '1;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset_init");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Single digit 2 held, latency from first sample.
    add(4'b1110, 7'h5B, 10);
    add(4'b1111, 7'h00, 3);
    // Scan 1, A, C, F across digits 0..3 with blanking.
    scan = '{7'h06, 7'h77, 7'h39, 7'h71};
    for (int d = 0; d < 4; d++) begin
      add(~(one << d), scan[d], 8);
      add(4'b1111, 7'h00, 2);
    end
    // Glitching segments on digit 1 never settle.
    for (int g = 0; g < 10; g++) add(4'b1101, (g % 2 == 0) ? 7'h06 : 7'h5B, 2);
    add(4'b1111, 7'h00, 3);
    // Good 5 then an illegal pattern on digit 2, then two enables at once.
    add(4'b1011, 7'h6D, 8);
    add(4'b1011, 7'h01, 8);
    add(4'b1111, 7'h00, 2);
    add(4'b1100, 7'h3F, 8);
    add(4'b1111, 7'h00, 3);
    // Timeout after one acceptance, then an acceptance on the expiry edge.
    add(4'b1110, 7'h3F, 8);
    add(4'b1111, 7'h00, 92);
    add(4'b1101, 7'h07, 8);
    add(4'b1111, 7'h00, 3);
    run_plan();

    // Fill all digits, then reset in the middle of the next digit.
    for (int d = 0; d < 4; d++) begin
      add(~(one << d), tbl[$urandom_range(0, 15)], 8);
      add(4'b1111, 7'h00, 2);
    end
    run_plan();
    dig_n = 4'b1101;
    seg_n = ~7'h6D;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_reset("reset_mid");
    dig_n = '1;
    seg_n = 7'h7F;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Randomised traffic, ending on a short blank tail.
    add_random(150);
    add(4'b1111, 7'h00, 10);
    run_plan();
    #2;
    mon_en = 1'b0;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL queue_drain: %0d expected events left, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
